// File: rtl/pkt_arb_pkg.sv
// Shared definitions for the packet input arbiter: arbitration modes,
// FSM state encoding and an elaboration-time log2 helper.
package pkt_arb_pkg;

    localparam logic [1:0] ARB_RR  = 2'd0;
    localparam logic [1:0] ARB_SP  = 2'd1;
    localparam logic [1:0] ARB_WRR = 2'd2;

    typedef enum logic {
        IDLE   = 1'b0,
        WR_PKT = 1'b1
    } arb_state_t;

    // Smallest r with 2**r >= n; used to size queue indices.
    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pkt_arb_select.sv
// Combinational grant selection: lowest eligible index in strict priority,
// otherwise first eligible queue at or after ptr with wrap-around.
module pkt_arb_select
    import pkt_arb_pkg::*;
#(
    parameter int NUM_QUEUES = 8,
    parameter int QW         = 3
) (
    input  logic [NUM_QUEUES-1:0] elig,
    input  logic [QW-1:0]         ptr,
    input  logic [1:0]            mode,
    output logic                  grant_valid,
    output logic [QW-1:0]         grant_idx
);
    logic [2*NUM_QUEUES-1:0] rot;

    // bit k of rot is elig[(ptr + k) mod NUM_QUEUES]
    assign rot = {elig, elig} >> ptr;

    always_comb begin
        int s;
        grant_valid = |elig;
        grant_idx   = '0;
        s           = 0;
        if (mode == ARB_SP) begin
            for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
                if (elig[i]) grant_idx = QW'(i);
            end
        end else begin
            for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
                if (rot[k]) begin
                    s = int'(ptr) + k;
                    if (s >= NUM_QUEUES) s = s - NUM_QUEUES;
                    grant_idx = QW'(s);
                end
            end
        end
    end

endmodule

// File: rtl/small_fifo.sv
// Show-ahead FIFO: dout always presents the head entry, rd_en pops it.
// Writes while full are dropped; nearly_full gives the producer one slot of slack.
module small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 2,
    parameter int NEARLY_FULL    = 2**MAX_DEPTH_BITS - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);
    localparam int DEPTH = 2**MAX_DEPTH_BITS;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;
    logic                      full;
    logic                      do_wr;
    logic                      do_rd;

    assign full        = (depth == (MAX_DEPTH_BITS+1)'(DEPTH));
    assign nearly_full = (depth >= (MAX_DEPTH_BITS+1)'(NEARLY_FULL));
    assign empty       = (depth == '0);
    assign do_wr       = wr_en && !full;
    assign do_rd       = rd_en && !empty;
    assign dout        = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr && !reset) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   depth <= depth + 1'b1;
                2'b01:   depth <= depth - 1'b1;
                default: depth <= depth;
            endcase
        end
    end

endmodule

// File: rtl/pkt_input_arbiter_wrr.sv
// Merges NUM_QUEUES packet streams into one, a whole packet at a time, with
// round-robin, strict-priority or weighted round-robin queue selection.
module pkt_input_arbiter_wrr
    import pkt_arb_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int NUM_QUEUES      = 8,
    parameter int QW              = log2(NUM_QUEUES),
    parameter int FIFO_DEPTH_BITS = 2,
    parameter int WEIGHT_WIDTH    = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0]   in_data,
    input  logic [NUM_QUEUES*CTRL_WIDTH-1:0]   in_ctrl,
    input  logic [NUM_QUEUES-1:0]              in_wr,
    output logic [NUM_QUEUES-1:0]              in_rdy,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [CTRL_WIDTH-1:0]              out_ctrl,
    output logic                               out_wr,
    input  logic                               out_rdy,
    input  logic [1:0]                         arb_mode,
    input  logic [NUM_QUEUES-1:0]              queue_enable,
    input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0] weights,
    output logic [QW-1:0]                      cur_queue,
    output logic                               pkt_done,
    output logic [QW-1:0]                      pkt_done_queue
);
    localparam int EW = DATA_WIDTH + CTRL_WIDTH;

    // Handshake: a source writes only while in_rdy is high; a word is popped
    // only in a cycle with out_rdy high and appears on out_* with out_wr next cycle.

    arb_state_t              state;
    arb_state_t              next_state;
    logic [EW-1:0]           fifo_dout [NUM_QUEUES];
    logic [NUM_QUEUES-1:0]   fifo_empty;
    logic [NUM_QUEUES-1:0]   fifo_nf;
    logic [NUM_QUEUES-1:0]   fifo_rd;
    logic [NUM_QUEUES-1:0]   elig;
    logic [WEIGHT_WIDTH-1:0] weight [NUM_QUEUES];
    logic [WEIGHT_WIDTH-1:0] credit [NUM_QUEUES];
    logic [QW-1:0]           ptr;
    logic [QW-1:0]           grant_idx;
    logic                    grant_valid;
    logic                    grant_now;
    logic                    pop;
    logic                    in_body;
    logic                    head_is_eop;
    logic [1:0]              pkt_mode;
    logic [EW-1:0]           head;
    logic [CTRL_WIDTH-1:0]   head_ctrl;

    function automatic logic [QW-1:0] next_q(input logic [QW-1:0] q);
        return (q == QW'(NUM_QUEUES - 1)) ? '0 : q + 1'b1;
    endfunction

    for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_queue
        small_fifo #(
            .WIDTH          (EW),
            .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
        ) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .din         ({in_ctrl[q*CTRL_WIDTH +: CTRL_WIDTH], in_data[q*DATA_WIDTH +: DATA_WIDTH]}),
            .wr_en       (in_wr[q]),
            .rd_en       (fifo_rd[q]),
            .dout        (fifo_dout[q]),
            .nearly_full (fifo_nf[q]),
            .empty       (fifo_empty[q])
        );
        assign in_rdy[q] = !fifo_nf[q];
        assign weight[q] = weights[q*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end

    assign elig = ~fifo_empty & queue_enable;

    pkt_arb_select #(
        .NUM_QUEUES (NUM_QUEUES),
        .QW         (QW)
    ) u_select (
        .elig        (elig),
        .ptr         (ptr),
        .mode        (arb_mode),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign head        = fifo_dout[cur_queue];
    assign head_ctrl   = head[EW-1 -: CTRL_WIDTH];
    // eop is the first non-zero ctrl word once a body word has been seen
    assign head_is_eop = in_body && (head_ctrl != '0);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_now) next_state = WR_PKT;
            WR_PKT:  if (pop && head_is_eop) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        grant_now = 1'b0;
        pop       = 1'b0;
        fifo_rd   = '0;
        case (state)
            IDLE:    grant_now = grant_valid && out_rdy;
            WR_PKT:  pop = out_rdy && !fifo_empty[cur_queue];
            default: ;
        endcase
        for (int q = 0; q < NUM_QUEUES; q++) begin
            fifo_rd[q] = pop && (cur_queue == QW'(q));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_wr         <= 1'b0;
            out_data       <= '0;
            out_ctrl       <= '0;
            pkt_done       <= 1'b0;
            pkt_done_queue <= '0;
            cur_queue      <= '0;
            ptr            <= '0;
            in_body        <= 1'b0;
            pkt_mode       <= ARB_RR;
            for (int q = 0; q < NUM_QUEUES; q++) credit[q] <= '0;
        end else begin
            out_wr   <= pop;
            pkt_done <= pop && head_is_eop;
            if (grant_now) begin
                cur_queue <= grant_idx;
                in_body   <= 1'b0;
                pkt_mode  <= arb_mode;
                // an exhausted credit is refilled when the queue wins a new turn
                if (arb_mode == ARB_WRR && credit[grant_idx] == '0) begin
                    credit[grant_idx] <= (weight[grant_idx] == '0) ? WEIGHT_WIDTH'(1)
                                                                   : weight[grant_idx];
                end
            end
            if (pop) begin
                out_data <= head[DATA_WIDTH-1:0];
                out_ctrl <= head_ctrl;
                if (head_ctrl == '0) in_body <= 1'b1;
                if (head_is_eop) begin
                    pkt_done_queue <= cur_queue;
                    case (pkt_mode)
                        ARB_SP: ;
                        ARB_WRR: begin
                            if (credit[cur_queue] > WEIGHT_WIDTH'(1)) begin
                                credit[cur_queue] <= credit[cur_queue] - 1'b1;
                                ptr               <= cur_queue;
                            end else begin
                                credit[cur_queue] <= '0;
                                ptr               <= next_q(cur_queue);
                            end
                        end
                        default: ptr <= next_q(cur_queue);
                    endcase
                end
            end
        end
    end

endmodule
